// File: rtl/rv32i_types.sv
// Shared RV32I types: CDB payload struct, FU type encoding
// and the CDB arbiter port map.
package rv32i_types;

  localparam int ROB_IDX_W  = 5;
  localparam int REG_ADDR_W = 5;
  localparam int CDB_PORTS  = 5;

  typedef enum logic [2:0] {
    T_NONE = 3'd0,
    T_ALU  = 3'd1,
    T_MUL  = 3'd2,
    T_DIV  = 3'd3,
    T_BR   = 3'd4,
    T_MEM  = 3'd5
  } types_t;

  typedef enum logic [2:0] {
    CDB_ALU = 3'd0,
    CDB_MUL = 3'd1,
    CDB_DIV = 3'd2,
    CDB_BR  = 3'd3,
    CDB_MEM = 3'd4
  } cdb_port_e;

  typedef struct packed {
    logic                  valid;
    logic [31:0]           data;
    logic [ROB_IDX_W-1:0]  rob_idx;
    logic [REG_ADDR_W-1:0] rd_addr;
  } cdb_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or
// after ptr wins; pointer state lives in the parent.
module rr_arbiter #(
  parameter int N = 5,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx
);

  // Rotating priority scan starting at ptr.
  always_comb begin
    int   idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = W'(idx);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB transmit arbiter: one holding slot per FU, round-robin
// broadcast on a registered CDB. Option: CDB_ARB_PERF_EN.
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int N_PORTS = CDB_PORTS,
  parameter int IDX_W   = ROB_IDX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [N_PORTS-1:0] fu_valid,
  output logic [N_PORTS-1:0] fu_ready,
  input  cdb_t [N_PORTS-1:0] fu_result,
  output cdb_t               cdb_out
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [31:0]        perf_grants [N_PORTS],
  output logic [31:0]        perf_stalls [N_PORTS]
`endif
);

  localparam int PW = $clog2(N_PORTS);

  logic [N_PORTS-1:0] hold_v;
  cdb_t               hold_d [N_PORTS];
  logic [PW-1:0]      rr_ptr;
  logic [N_PORTS-1:0] grant;
  logic [PW-1:0]      grant_idx;
  logic [N_PORTS-1:0] accept;
  logic [IDX_W-1:0]   grant_rob;
  logic [PW-1:0]      ptr_next;

  rr_arbiter #(
    .N (N_PORTS),
    .W (PW)
  ) u_rr (
    .req       (hold_v),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // A slot can take a new result if empty or draining now.
  assign fu_ready  = {N_PORTS{~flush}} & (~hold_v | grant);
  assign accept    = fu_valid & fu_ready;
  assign grant_rob = hold_d[grant_idx].rob_idx;
  assign ptr_next  = (grant_idx == PW'(N_PORTS - 1))
                   ? '0 : grant_idx + 1'b1;

  // Holding slots, rr pointer and registered broadcast.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_v  <= '0;
      rr_ptr  <= '0;
      cdb_out <= '0;
      for (int i = 0; i < N_PORTS; i++) hold_d[i] <= '0;
    end else if (flush) begin
      hold_v        <= '0;
      cdb_out.valid <= 1'b0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (accept[i]) begin
          hold_v[i] <= 1'b1;
          hold_d[i] <= fu_result[i];
        end else if (grant[i]) begin
          hold_v[i] <= 1'b0;
        end
      end
      if (|hold_v) begin
        cdb_out.valid   <= 1'b1;
        cdb_out.data    <= hold_d[grant_idx].data;
        cdb_out.rob_idx <= grant_rob;
        cdb_out.rd_addr <= hold_d[grant_idx].rd_addr;
        rr_ptr          <= ptr_next;
      end else begin
        cdb_out.valid <= 1'b0;
      end
    end
  end

`ifdef CDB_ARB_PERF_EN
  // Per-port grant and stall counters; survive flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_PORTS; i++) begin
        perf_grants[i] <= '0;
        perf_stalls[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (grant[i] && !flush)
          perf_grants[i] <= perf_grants[i] + 32'd1;
        if (fu_valid[i] && !fu_ready[i])
          perf_stalls[i] <= perf_stalls[i] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed table-driven bench for cdb_arbiter, plus
// hand-written latency and reset-during-broadcast sequences.
module tb_cdb_arbiter;
  import rv32i_types::*;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [4:0] fu_valid;
  logic [4:0] fu_ready;
  cdb_t [4:0] fu_result;
  cdb_t       cdb_out;
`ifdef CDB_ARB_PERF_EN
  logic [31:0] perf_grants [5];
  logic [31:0] perf_stalls [5];
`endif

  cdb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .fu_valid  (fu_valid),
    .fu_ready  (fu_ready),
    .fu_result (fu_result),
    .cdb_out   (cdb_out)
`ifdef CDB_ARB_PERF_EN
    ,
    .perf_grants (perf_grants),
    .perf_stalls (perf_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        chk;
    logic        rst_n;
    logic        flush;
    logic [4:0]  valid;
    logic [3:0]  tag;
    logic        ev;
    logic [31:0] edata;
    logic [4:0]  erob;
    logic [4:0]  erdy;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  vec_t tbl [27];

  function automatic vec_t mk(
    logic c, logic r, logic f, logic [4:0] v, logic [3:0] t,
    logic ev, logic [31:0] ed, logic [4:0] er, logic [4:0] ey);
    vec_t x;
    x.chk = c; x.rst_n = r; x.flush = f; x.valid = v;
    x.tag = t; x.ev = ev; x.edata = ed; x.erob = er;
    x.erdy = ey;
    return x;
  endfunction

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Port i payload for tag t: data C0DE_0000|{t,i}, rob t+i.
  task automatic drive(logic [4:0] v, logic [3:0] t);
    fu_valid = v;
    for (int i = 0; i < 5; i++) begin
      fu_result[i].valid   = 1'b0;
      fu_result[i].data    = 32'hC0DE_0000 | {24'd0, t, 4'(i)};
      fu_result[i].rob_idx = 5'(t) + 5'(i);
      fu_result[i].rd_addr = 5'(i + 8);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    drive(5'h00, 4'd0);

    tbl[0]  = mk(0,0,0,5'h1F,0, 0,32'h0,0,5'h00);
    tbl[1]  = mk(1,0,0,5'h1F,0, 0,32'h0,0,5'h1F);
    tbl[2]  = mk(1,1,0,5'h00,0, 0,32'h0,0,5'h1F);
    tbl[3]  = mk(1,1,0,5'h1F,0, 0,32'h0,0,5'h1F);
    tbl[4]  = mk(1,1,0,5'h00,0, 0,32'h0,0,5'h01);
    tbl[5]  = mk(1,1,0,5'h00,0, 1,32'hC0DE0000,0,5'h03);
    tbl[6]  = mk(1,1,0,5'h00,0, 1,32'hC0DE0001,1,5'h07);
    tbl[7]  = mk(1,1,0,5'h00,0, 1,32'hC0DE0002,2,5'h0F);
    tbl[8]  = mk(1,1,0,5'h00,0, 1,32'hC0DE0003,3,5'h1F);
    tbl[9]  = mk(1,1,0,5'h00,0, 1,32'hC0DE0004,4,5'h1F);
    tbl[10] = mk(1,1,0,5'h11,1, 0,32'h0,0,5'h1F);
    tbl[11] = mk(1,1,0,5'h11,1, 0,32'h0,0,5'h0F);
    tbl[12] = mk(1,1,0,5'h11,1, 1,32'hC0DE0010,1,5'h1E);
    tbl[13] = mk(1,1,0,5'h11,1, 1,32'hC0DE0014,5,5'h0F);
    tbl[14] = mk(1,1,0,5'h00,0, 1,32'hC0DE0010,1,5'h1E);
    tbl[15] = mk(1,1,0,5'h00,0, 1,32'hC0DE0014,5,5'h1F);
    tbl[16] = mk(1,1,0,5'h06,2, 1,32'hC0DE0010,1,5'h1F);
    tbl[17] = mk(1,1,1,5'h00,0, 0,32'h0,0,5'h00);
    tbl[18] = mk(1,1,0,5'h04,3, 0,32'h0,0,5'h1F);
    tbl[19] = mk(1,1,0,5'h00,0, 0,32'h0,0,5'h1F);
    tbl[20] = mk(1,1,0,5'h08,4, 1,32'hC0DE0032,5,5'h1F);
    tbl[21] = mk(1,1,0,5'h08,5, 0,32'h0,0,5'h1F);
    tbl[22] = mk(1,1,0,5'h08,6, 1,32'hC0DE0043,7,5'h1F);
    tbl[23] = mk(1,1,0,5'h08,7, 1,32'hC0DE0053,8,5'h1F);
    tbl[24] = mk(1,1,0,5'h00,0, 1,32'hC0DE0063,9,5'h1F);
    tbl[25] = mk(1,1,0,5'h00,0, 1,32'hC0DE0073,10,5'h1F);
    tbl[26] = mk(1,1,0,5'h00,0, 0,32'h0,0,5'h1F);

    for (int r = 0; r < 27; r++) begin
      @(negedge clk);
      rst_n = tbl[r].rst_n;
      flush = tbl[r].flush;
      drive(tbl[r].valid, tbl[r].tag);
      #1;
      if (tbl[r].chk) begin
        check($sformatf("row%0d ready", r),
              32'(fu_ready), 32'(tbl[r].erdy));
        check($sformatf("row%0d valid", r),
              32'(cdb_out.valid), 32'(tbl[r].ev));
        if (tbl[r].ev) begin
          check($sformatf("row%0d data", r),
                cdb_out.data, tbl[r].edata);
          check($sformatf("row%0d rob", r),
                32'(cdb_out.rob_idx), 32'(tbl[r].erob));
        end
      end
    end

`ifdef CDB_ARB_PERF_EN
    @(negedge clk);
    #1;
    check("grants0", perf_grants[0], 32'd4);
    check("grants1", perf_grants[1], 32'd1);
    check("grants2", perf_grants[2], 32'd2);
    check("grants3", perf_grants[3], 32'd5);
    check("grants4", perf_grants[4], 32'd3);
    check("stalls0", perf_stalls[0], 32'd1);
    check("stalls4", perf_stalls[4], 32'd2);
    check("stalls1", perf_stalls[1], 32'd0);
`endif

    // Single result on port 0: visible exactly two cycles later.
    @(negedge clk);
    drive(5'h00, 4'd0);
    fu_valid             = 5'h01;
    fu_result[0].data    = 32'hDEADBEEF;
    fu_result[0].rob_idx = 5'd3;
    fu_result[0].rd_addr = 5'd7;
    #1;
    check("single ready", 32'(fu_ready), 32'h1F);
    @(negedge clk);
    fu_valid = 5'h00;
    #1;
    check("single early", 32'(cdb_out.valid), 32'd0);
    @(negedge clk);
    #1;
    check("single valid", 32'(cdb_out.valid), 32'd1);
    check("single data", cdb_out.data, 32'hDEADBEEF);
    check("single rob", 32'(cdb_out.rob_idx), 32'd3);
    check("single rd", 32'(cdb_out.rd_addr), 32'd7);
    @(negedge clk);
    #1;
    check("single pulse", 32'(cdb_out.valid), 32'd0);

    // Reset landing on the broadcast edge drops the result.
    @(negedge clk);
    drive(5'h02, 4'd8);
    @(negedge clk);
    drive(5'h00, 4'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rstbc valid", 32'(cdb_out.valid), 32'd0);
    check("rstbc rob", 32'(cdb_out.rob_idx), 32'd0);
    check("rstbc ready", 32'(fu_ready), 32'h1F);
    @(negedge clk);
    #1;
    check("rstbc after", 32'(cdb_out.valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
